// File: rtl/reg_scoreboard_dec_if.sv
// Issue/writeback bundle between the pipeline control and the register scoreboard.
// The master side drives issue and writeback requests, and the slave side returns decode and hazard status.
interface reg_scoreboard_dec_if #(
    parameter int ADDR_W = 5
);
    localparam int NREGS = 1 << ADDR_W;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              issue_wr;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [NREGS-1:0]  wb_onehot;
    logic [NREGS-1:0]  busy_vec;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              issue_stall;
    logic              err_underflow;

    modport master (
        output issue_valid, issue_rd, issue_wr, rs1, rs2, wb_valid, wb_rd,
        input  wb_onehot, busy_vec, rs1_busy, rs2_busy, issue_stall, err_underflow
    );

    modport slave (
        input  issue_valid, issue_rd, issue_wr, rs1, rs2, wb_valid, wb_rd,
        output wb_onehot, busy_vec, rs1_busy, rs2_busy, issue_stall, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard_dec.sv
// Writeback address decoder and per-register pending-write scoreboard.
// The scoreboard raises the issue stall on RAW hazards and when a destination's pending counter is saturated.
module reg_scoreboard_dec #(
    parameter int ADDR_W    = 5,
    parameter int CNT_W     = 2,
    parameter int ZERO_HARD = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_scoreboard_dec_if.slave  bus
);
    localparam int NREGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Register 0 is excluded from tracking when it is hardwired.
    function automatic logic is_tracked(input logic [ADDR_W-1:0] addr);
        is_tracked = (ZERO_HARD == 0) || (addr != {ADDR_W{1'b0}});
    endfunction

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic [NREGS-1:0] wb_onehot_q;
    logic [NREGS-1:0] wb_onehot_d;
    logic             err_underflow_q;
    logic             err_underflow_d;

    logic             rs1_busy_s;
    logic             rs2_busy_s;
    logic             rd_full_s;
    logic             issue_stall_s;
    logic             issue_acc_s;
    logic             wb_dec_s;
    logic             underflow_s;
    logic [NREGS-1:0] inc_vec_s;
    logic [NREGS-1:0] dec_vec_s;
    logic [NREGS-1:0] busy_vec_s;

    // Hazard detection from the registered counters; no writeback bypass.
    always_comb begin
        rs1_busy_s    = (cnt_q[bus.rs1] != CNT_ZERO);
        rs2_busy_s    = (cnt_q[bus.rs2] != CNT_ZERO);
        rd_full_s     = (cnt_q[bus.issue_rd] == CNT_MAX);
        issue_stall_s = bus.issue_valid & (rs1_busy_s | rs2_busy_s | (bus.issue_wr & rd_full_s));
        issue_acc_s   = bus.issue_valid & ~issue_stall_s & bus.issue_wr & is_tracked(bus.issue_rd);
        wb_dec_s      = bus.wb_valid & is_tracked(bus.wb_rd);
        underflow_s   = wb_dec_s & (cnt_q[bus.wb_rd] == CNT_ZERO);
    end

    // Per-register increment/decrement strobes, write-enable decode and busy flags.
    always_comb begin
        inc_vec_s   = {NREGS{1'b0}};
        dec_vec_s   = {NREGS{1'b0}};
        wb_onehot_d = {NREGS{1'b0}};
        busy_vec_s  = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            inc_vec_s[i]   = issue_acc_s & (bus.issue_rd == ADDR_W'(i));
            dec_vec_s[i]   = wb_dec_s & (bus.wb_rd == ADDR_W'(i));
            wb_onehot_d[i] = dec_vec_s[i];
            busy_vec_s[i]  = (cnt_q[i] != CNT_ZERO);
        end
    end

    // Counter next state: an empty counter holds on a lone decrement and reaches 1 on a paired issue.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            case ({inc_vec_s[i], dec_vec_s[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
                2'b01:   cnt_d[i] = (cnt_q[i] == CNT_ZERO) ? CNT_ZERO : (cnt_q[i] - CNT_ONE);
                2'b11:   cnt_d[i] = (cnt_q[i] == CNT_ZERO) ? CNT_ONE : cnt_q[i];
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        err_underflow_d = err_underflow_q | underflow_s;
    end

    // State registers with synchronous active-low reset overriding all events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            wb_onehot_q     <= {NREGS{1'b0}};
            err_underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            wb_onehot_q     <= wb_onehot_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign bus.wb_onehot     = wb_onehot_q;
    assign bus.busy_vec      = busy_vec_s;
    assign bus.rs1_busy      = rs1_busy_s;
    assign bus.rs2_busy      = rs2_busy_s;
    assign bus.issue_stall   = issue_stall_s;
    assign bus.err_underflow = err_underflow_q;
endmodule

// File: tb/tb_reg_scoreboard_dec.sv
// Table-driven bench for reg_scoreboard_dec with a queue of expected registered results.
module tb_reg_scoreboard_dec;
    logic clk;
    logic rst_n;

    reg_scoreboard_dec_if #(.ADDR_W(5)) bus ();

    reg_scoreboard_dec #(.ADDR_W(5), .CNT_W(2), .ZERO_HARD(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [4:0]  ird;
        logic        iwr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wv;
        logic [4:0]  wrd;
        logic        chk_comb;
        logic        e_stall;
        logic        e_b1;
        logic        e_b2;
        logic [31:0] e_busy;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [31:0] onehot;
        logic [31:0] busy;
        logic        chk_busy;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic r, input logic iv, input logic [4:0] ird, input logic iwr,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic wv,
                                input logic [4:0] wrd, input logic cc, input logic st, input logic b1,
                                input logic b2, input logic [31:0] busy, input logic err);
        vec_t v;
        v.rst_n = r; v.iv = iv; v.ird = ird; v.iwr = iwr; v.rs1 = rs1; v.rs2 = rs2;
        v.wv = wv; v.wrd = wrd; v.chk_comb = cc; v.e_stall = st; v.e_b1 = b1; v.e_b2 = b2;
        v.e_busy = busy; v.e_err = err;
        return v;
    endfunction

    function automatic logic [31:0] exp_onehot(input logic r, input logic wv, input logic [4:0] wrd);
        logic [31:0] one;
        one = 32'd1;
        if (!r || !wv || wrd == 5'd0) return 32'd0;
        return one << wrd;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [4:0] ird, input logic iwr,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic wv, input logic [4:0] wrd);
        rst_n = r; bus.issue_valid = iv; bus.issue_rd = ird; bus.issue_wr = iwr;
        bus.rs1 = rs1; bus.rs2 = rs2; bus.wb_valid = wv; bus.wb_rd = wrd;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, " queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " wb_onehot"}, bus.wb_onehot, e.onehot);
            chk({tag, " err_underflow"}, {31'd0, bus.err_underflow}, {31'd0, e.err});
            if (e.chk_busy) chk({tag, " busy_vec"}, bus.busy_vec, e.busy);
        end
    endtask

    initial begin
        exp_t e;
        int   got;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);

        // reset with activity, decode, RAW, saturation, simultaneous, underflow
        vecs.push_back(mk(1'b0,1'b1,5'd7, 1'b1,5'd0, 5'd0, 1'b1,5'd4, 1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0));
        vecs.push_back(mk(1'b0,1'b1,5'd7, 1'b1,5'd0, 5'd0, 1'b1,5'd4, 1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd13,1'b1,5'd1, 5'd2, 1'b0,5'd0, 1'b1,1'b0,1'b0,1'b0,32'h0000_2000,1'b0));
        vecs.push_back(mk(1'b1,1'b0,5'd0, 1'b0,5'd13,5'd0, 1'b1,5'd13,1'b1,1'b0,1'b1,1'b0,32'h0000_0000,1'b0));
        vecs.push_back(mk(1'b1,1'b0,5'd0, 1'b0,5'd13,5'd0, 1'b1,5'd0, 1'b1,1'b0,1'b0,1'b0,32'h0000_0000,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd7, 1'b1,5'd0, 5'd0, 1'b0,5'd0, 1'b1,1'b0,1'b0,1'b0,32'h0000_0080,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd8, 1'b1,5'd7, 5'd0, 1'b0,5'd0, 1'b1,1'b1,1'b1,1'b0,32'h0000_0080,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd8, 1'b1,5'd7, 5'd0, 1'b1,5'd7, 1'b1,1'b1,1'b1,1'b0,32'h0000_0000,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd8, 1'b1,5'd0, 5'd7, 1'b0,5'd0, 1'b1,1'b0,1'b0,1'b0,32'h0000_0100,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd3, 1'b1,5'd0, 5'd0, 1'b0,5'd0, 1'b1,1'b0,1'b0,1'b0,32'h0000_0108,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd3, 1'b1,5'd0, 5'd0, 1'b0,5'd0, 1'b1,1'b0,1'b0,1'b0,32'h0000_0108,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd3, 1'b1,5'd0, 5'd0, 1'b0,5'd0, 1'b1,1'b0,1'b0,1'b0,32'h0000_0108,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd3, 1'b1,5'd0, 5'd0, 1'b0,5'd0, 1'b1,1'b1,1'b0,1'b0,32'h0000_0108,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd3, 1'b0,5'd5, 5'd6, 1'b0,5'd0, 1'b1,1'b0,1'b0,1'b0,32'h0000_0108,1'b0));
        vecs.push_back(mk(1'b1,1'b0,5'd0, 1'b0,5'd0, 5'd0, 1'b1,5'd3, 1'b1,1'b0,1'b0,1'b0,32'h0000_0108,1'b0));
        vecs.push_back(mk(1'b1,1'b0,5'd0, 1'b0,5'd0, 5'd0, 1'b1,5'd3, 1'b1,1'b0,1'b0,1'b0,32'h0000_0108,1'b0));
        vecs.push_back(mk(1'b1,1'b0,5'd0, 1'b0,5'd0, 5'd0, 1'b1,5'd3, 1'b1,1'b0,1'b0,1'b0,32'h0000_0100,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd9, 1'b1,5'd0, 5'd0, 1'b0,5'd0, 1'b1,1'b0,1'b0,1'b0,32'h0000_0300,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd9, 1'b1,5'd0, 5'd0, 1'b1,5'd9, 1'b1,1'b0,1'b0,1'b0,32'h0000_0300,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd10,1'b1,5'd0, 5'd0, 1'b1,5'd8, 1'b1,1'b0,1'b0,1'b0,32'h0000_0600,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd0, 1'b1,5'd0, 5'd0, 1'b0,5'd0, 1'b1,1'b0,1'b0,1'b0,32'h0000_0600,1'b0));
        vecs.push_back(mk(1'b1,1'b0,5'd0, 1'b0,5'd0, 5'd10,1'b1,5'd9, 1'b1,1'b0,1'b0,1'b1,32'h0000_0400,1'b0));
        vecs.push_back(mk(1'b1,1'b0,5'd0, 1'b0,5'd4, 5'd0, 1'b1,5'd4, 1'b1,1'b0,1'b0,1'b0,32'h0000_0400,1'b1));
        vecs.push_back(mk(1'b1,1'b0,5'd0, 1'b0,5'd4, 5'd0, 1'b0,5'd0, 1'b1,1'b0,1'b0,1'b0,32'h0000_0400,1'b1));
        vecs.push_back(mk(1'b0,1'b1,5'd6, 1'b1,5'd0, 5'd0, 1'b1,5'd6, 1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd5, 1'b1,5'd0, 5'd0, 1'b1,5'd5, 1'b1,1'b0,1'b0,1'b0,32'h0000_0020,1'b1));
        vecs.push_back(mk(1'b1,1'b0,5'd0, 1'b0,5'd5, 5'd0, 1'b0,5'd0, 1'b1,1'b0,1'b1,1'b0,32'h0000_0020,1'b1));

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k].rst_n, vecs[k].iv, vecs[k].ird, vecs[k].iwr,
                  vecs[k].rs1, vecs[k].rs2, vecs[k].wv, vecs[k].wrd);
            e.onehot   = exp_onehot(vecs[k].rst_n, vecs[k].wv, vecs[k].wrd);
            e.busy     = vecs[k].e_busy;
            e.chk_busy = 1'b1;
            e.err      = vecs[k].e_err;
            exp_q.push_back(e);
            #1;
            if (vecs[k].chk_comb) begin
                chk($sformatf("v%0d issue_stall", k), {31'd0, bus.issue_stall}, {31'd0, vecs[k].e_stall});
                chk($sformatf("v%0d rs1_busy", k), {31'd0, bus.rs1_busy}, {31'd0, vecs[k].e_b1});
                chk($sformatf("v%0d rs2_busy", k), {31'd0, bus.rs2_busy}, {31'd0, vecs[k].e_b2});
            end
            @(posedge clk);
            #1;
            pop_check($sformatf("v%0d", k));
        end

        // RAW stall must persist through the writeback cycle and drop exactly one cycle later
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd20, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
        @(posedge clk);
        got = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 5'd21, 1'b1, 5'd20, 5'd0, (c == 2), 5'd20);
            #1;
            if (!bus.issue_stall) begin
                got = c;
                break;
            end
            @(posedge clk);
        end
        chk("raw stall release cycle", 32'(got), 32'd3);
        @(posedge clk);

        // decode sweep over every address; err_underflow stays sticky throughout
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'(a));
            e.onehot   = exp_onehot(1'b1, 1'b1, 5'(a));
            e.busy     = 32'd0;
            e.chk_busy = 1'b0;
            e.err      = 1'b1;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            pop_check($sformatf("sweep%0d", a));
        end

        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
